// File: rtl/snake_body_tracker.sv
// Snake body position store: shifts segment positions one cell per move tick,
// tracks length/growth, and flags wall or self collisions as game over.
module snake_body_tracker #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int STEP     = 10,
    parameter int START_X  = 320,
    parameter int START_Y  = 240,
    parameter int H_MAX    = 630,
    parameter int V_MAX    = 470
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   move_tick,
    input  logic [1:0]             dir_in,
    input  logic                   grow,
    output logic [11*MAX_LEN-1:0]  seg_x,
    output logic [11*MAX_LEN-1:0]  seg_y,
    output logic [MAX_LEN-1:0]     seg_active,
    output logic [4:0]             length,
    output logic                   busy,
    output logic                   dead
);

    typedef enum logic [2:0] {IDLE, RUN, SHIFT, CHECK, DEAD} state_t;

    localparam logic signed [11:0] STEP_S  = 12'(STEP);
    localparam logic signed [11:0] H_MAX_S = 12'(H_MAX);
    localparam logic signed [11:0] V_MAX_S = 12'(V_MAX);

    state_t              state;
    logic [10:0]         pos_x [MAX_LEN];
    logic [10:0]         pos_y [MAX_LEN];
    logic [1:0]          dir;
    logic                grow_pending;
    logic signed [11:0]  next_x;
    logic signed [11:0]  next_y;
    logic                wall_hit;
    logic                self_hit;

    function automatic logic [MAX_LEN-1:0] active_mask(input logic [4:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++)
            m[i] = (i < 32'(len));
        return m;
    endfunction

    always_comb begin
        next_x = $signed({1'b0, pos_x[0]});
        next_y = $signed({1'b0, pos_y[0]});
        case (dir)
            2'b00:   next_x = $signed({1'b0, pos_x[0]}) + STEP_S;
            2'b01:   next_x = $signed({1'b0, pos_x[0]}) - STEP_S;
            2'b10:   next_y = $signed({1'b0, pos_y[0]}) - STEP_S;
            default: next_y = $signed({1'b0, pos_y[0]}) + STEP_S;
        endcase
        wall_hit = (next_x < 0) || (next_x > H_MAX_S) ||
                   (next_y < 0) || (next_y > V_MAX_S);
    end

    always_comb begin
        self_hit = 1'b0;
        for (int unsigned j = 1; j < MAX_LEN; j++)
            if (j < 32'(length) && pos_x[j] == pos_x[0] && pos_y[j] == pos_y[0])
                self_hit = 1'b1;
    end

    // Restart from DEAD shares the reset load so both paths stay identical.
    always_ff @(posedge clk) begin
        if (rst || (state == DEAD && start)) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                pos_x[i] <= 11'(START_X - int'(i) * STEP);
                pos_y[i] <= 11'(START_Y);
            end
            length       <= 5'(INIT_LEN);
            seg_active   <= active_mask(5'(INIT_LEN));
            dir          <= 2'b00;
            grow_pending <= 1'b0;
            busy         <= 1'b0;
            dead         <= 1'b0;
            state        <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) state <= RUN;
                RUN: begin
                    if (grow) grow_pending <= 1'b1;
                    if (move_tick) begin
                        if (!(dir_in[1] == dir[1] && dir_in[0] != dir[0]))
                            dir <= dir_in;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Pending grow is consumed here; a grow on this edge arms the next move.
                    grow_pending <= grow;
                    if (wall_hit) begin
                        busy  <= 1'b0;
                        dead  <= 1'b1;
                        state <= DEAD;
                    end else begin
                        for (int unsigned i = 1; i < MAX_LEN; i++) begin
                            pos_x[i] <= pos_x[i-1];
                            pos_y[i] <= pos_y[i-1];
                        end
                        pos_x[0] <= next_x[10:0];
                        pos_y[0] <= next_y[10:0];
                        if (grow_pending && length < 5'(MAX_LEN)) begin
                            length     <= length + 5'd1;
                            seg_active <= active_mask(length + 5'd1);
                        end
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (grow) grow_pending <= 1'b1;
                    busy <= 1'b0;
                    if (self_hit) begin
                        dead  <= 1'b1;
                        state <= DEAD;
                    end else begin
                        state <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign seg_x[11*g +: 11] = pos_x[g];
        assign seg_y[11*g +: 11] = pos_y[g];
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Self-checking bench for snake_body_tracker: directed table, corner-case
// sequences and random stimulus against a queue-based game model.
module tb_snake_body_tracker;

    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;
    localparam int STEP     = 10;
    localparam int START_X  = 320;
    localparam int START_Y  = 240;
    localparam int H_MAX    = 630;
    localparam int V_MAX    = 470;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, move_tick = 1'b0, grow = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic [11*MAX_LEN-1:0] seg_x, seg_y;
    logic [MAX_LEN-1:0]    seg_active;
    logic [4:0]            length;
    logic                  busy, dead;

    snake_body_tracker #(
        .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .STEP(STEP),
        .START_X(START_X), .START_Y(START_Y), .H_MAX(H_MAX), .V_MAX(V_MAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .move_tick(move_tick),
        .dir_in(dir_in), .grow(grow), .seg_x(seg_x), .seg_y(seg_y),
        .seg_active(seg_active), .length(length), .busy(busy), .dead(dead)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Game model: body is a queue of positions, head at index 0.
    typedef enum {M_IDLE, M_RUN, M_SHIFT, M_CHECK, M_DEAD} mstate_t;
    mstate_t ms = M_IDLE;
    int mx[$];
    int my[$];
    int mlen = 0;
    int mdir = 0;
    bit mgp  = 0;

    function automatic void model_init();
        mx.delete();
        my.delete();
        for (int i = 0; i < MAX_LEN; i++) begin
            mx.push_back(START_X - i * STEP);
            my.push_back(START_Y);
        end
        mlen = INIT_LEN;
        mdir = 0;
        mgp  = 0;
        ms   = M_IDLE;
    endfunction

    function automatic bit opposite(input int a, input int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) ||
               (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    function automatic void model_step();
        int nx, ny;
        bit hit;
        if (rst) begin
            model_init();
            return;
        end
        case (ms)
            M_IDLE: if (start) ms = M_RUN;
            M_RUN: begin
                if (grow) mgp = 1;
                if (move_tick) begin
                    if (!opposite(int'(dir_in), mdir)) mdir = int'(dir_in);
                    ms = M_SHIFT;
                end
            end
            M_SHIFT: begin
                nx = mx[0];
                ny = my[0];
                if (mdir == 0) nx += STEP;
                else if (mdir == 1) nx -= STEP;
                else if (mdir == 2) ny -= STEP;
                else ny += STEP;
                if (nx < 0 || nx > H_MAX || ny < 0 || ny > V_MAX) begin
                    ms = M_DEAD;
                end else begin
                    mx.push_front(nx); void'(mx.pop_back());
                    my.push_front(ny); void'(my.pop_back());
                    if (mgp && mlen < MAX_LEN) mlen++;
                    ms = M_CHECK;
                end
                mgp = grow;
            end
            M_CHECK: begin
                if (grow) mgp = 1;
                hit = 0;
                for (int j = 1; j < mlen; j++)
                    if (mx[j] == mx[0] && my[j] == my[0]) hit = 1;
                ms = hit ? M_DEAD : M_RUN;
            end
            M_DEAD: if (start) model_init();
            default: ;
        endcase
    endfunction

    task automatic compare_all();
        logic [11*MAX_LEN-1:0] ex, ey;
        logic [MAX_LEN-1:0]    ea;
        for (int i = 0; i < MAX_LEN; i++) begin
            ex[11*i +: 11] = 11'(mx[i]);
            ey[11*i +: 11] = 11'(my[i]);
            ea[i] = (i < mlen);
        end
        check("seg_x", 176'(seg_x), 176'(ex));
        check("seg_y", 176'(seg_y), 176'(ey));
        check("seg_active", 176'(seg_active), 176'(ea));
        check("length", 176'(length), 176'(mlen));
        check("busy", 176'(busy), 176'(ms == M_SHIFT || ms == M_CHECK));
        check("dead", 176'(dead), 176'(ms == M_DEAD));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic step_in(input logic r, input logic s, input logic t,
                           input logic g, input logic [1:0] d);
        rst = r; start = s; move_tick = t; grow = g; dir_in = d;
        cycle();
    endtask

    task automatic do_move(input logic [1:0] d, input logic g);
        step_in(0, 0, 1, g, d);
        step_in(0, 0, 0, 0, d);
        step_in(0, 0, 0, 0, d);
    endtask

    typedef struct {
        logic       rst, start, tick, grow;
        logic [1:0] dir;
        int         hx, hy, s2x, len;
        logic       busy, dead;
    } vec_t;
    vec_t tbl[17];

    initial begin
        int old_x, old_y;
        tbl[0]  = '{1, 0, 0, 0, 2'b00, 320, 240, 300, 3, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 2'b00, 320, 240, 300, 3, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 2'b00, 320, 240, 300, 3, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 2'b00, 330, 240, 310, 3, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 2'b00, 330, 240, 310, 3, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 2'b00, 330, 240, 310, 3, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 2'b00, 340, 240, 320, 3, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 2'b00, 340, 240, 320, 3, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 2'b00, 340, 240, 320, 3, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 2'b00, 350, 240, 330, 3, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 2'b00, 350, 240, 330, 3, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 2'b01, 350, 240, 330, 3, 1, 0};
        tbl[12] = '{0, 0, 1, 0, 2'b01, 360, 240, 340, 3, 1, 0};
        tbl[13] = '{0, 0, 1, 0, 2'b01, 360, 240, 340, 3, 0, 0};
        tbl[14] = '{0, 0, 1, 0, 2'b10, 360, 240, 340, 3, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 2'b10, 360, 230, 350, 3, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 2'b10, 360, 230, 350, 3, 0, 0};

        for (int k = 0; k < 17; k++) begin
            step_in(tbl[k].rst, tbl[k].start, tbl[k].tick, tbl[k].grow, tbl[k].dir);
            check($sformatf("tbl%0d head_x", k), 176'(seg_x[10:0]), 176'(tbl[k].hx));
            check($sformatf("tbl%0d head_y", k), 176'(seg_y[10:0]), 176'(tbl[k].hy));
            check($sformatf("tbl%0d seg2_x", k), 176'(seg_x[32:22]), 176'(tbl[k].s2x));
            check($sformatf("tbl%0d length", k), 176'(length), 176'(tbl[k].len));
            check($sformatf("tbl%0d busy", k), 176'(busy), 176'(tbl[k].busy));
            check($sformatf("tbl%0d dead", k), 176'(dead), 176'(tbl[k].dead));
            if (k == 0) begin
                check("reset seg1_x", 176'(seg_x[21:11]), 176'(310));
                check("reset seg_active", 176'(seg_active), 176'(16'h0007));
            end
        end

        // Grow by one: new tail slot takes the old seg2 position.
        old_x = mx[2];
        old_y = my[2];
        step_in(0, 0, 0, 1, 2'b10);
        step_in(0, 0, 1, 0, 2'b10);
        step_in(0, 0, 0, 0, 2'b10);
        check("grow length", 176'(length), 176'(4));
        check("grow seg_active", 176'(seg_active), 176'(16'h000F));
        check("grow seg3_x", 176'(seg_x[43:33]), 176'(old_x));
        check("grow seg3_y", 176'(seg_y[43:33]), 176'(old_y));
        check("grow seg3_x const", 176'(seg_x[43:33]), 176'(350));
        step_in(0, 0, 0, 0, 2'b10);
        for (int n = 0; n < 12; n++) do_move(2'b10, 1'b1);
        check("length at max", 176'(length), 176'(16));
        do_move(2'b10, 1'b1);
        check("length saturates", 176'(length), 176'(16));
        check("seg_active full", 176'(seg_active), 176'(16'hFFFF));

        // Walk to the right wall, then one more step dies without moving.
        for (int n = 0; n < 27; n++) do_move(2'b00, 1'b0);
        check("at wall head_x", 176'(seg_x[10:0]), 176'(630));
        step_in(0, 0, 1, 0, 2'b00);
        step_in(0, 0, 0, 0, 2'b00);
        check("wall dead after E1", 176'(dead), 176'(1));
        check("wall head unchanged", 176'(seg_x[10:0]), 176'(630));
        step_in(0, 0, 1, 0, 2'b00);
        check("dead holds", 176'(dead), 176'(1));
        step_in(0, 1, 0, 0, 2'b00);
        check("restart head_x", 176'(seg_x[10:0]), 176'(320));
        check("restart length", 176'(length), 176'(3));
        check("restart dead", 176'(dead), 176'(0));
        step_in(0, 0, 1, 0, 2'b00);
        check("tick in IDLE dropped", 176'(busy), 176'(0));

        // Self collision with length 5: right, down, left, up.
        step_in(1, 0, 0, 0, 2'b00);
        step_in(0, 1, 0, 0, 2'b00);
        do_move(2'b00, 1'b1);
        do_move(2'b00, 1'b1);
        check("len5", 176'(length), 176'(5));
        do_move(2'b11, 1'b0);
        do_move(2'b01, 1'b0);
        step_in(0, 0, 1, 0, 2'b10);
        step_in(0, 0, 0, 0, 2'b10);
        check("self no dead after E1", 176'(dead), 176'(0));
        check("self head_y", 176'(seg_y[10:0]), 176'(240));
        step_in(0, 0, 0, 0, 2'b10);
        check("self dead after E2", 176'(dead), 176'(1));

        // Reset while in SHIFT.
        step_in(0, 1, 0, 0, 2'b00);
        step_in(0, 1, 0, 0, 2'b00);
        step_in(0, 0, 1, 0, 2'b00);
        check("in shift busy", 176'(busy), 176'(1));
        step_in(1, 0, 0, 0, 2'b00);
        check("rst in shift head_x", 176'(seg_x[10:0]), 176'(320));
        check("rst in shift busy", 176'(busy), 176'(0));
        check("rst in shift length", 176'(length), 176'(3));

        // Random play against the model.
        for (int n = 0; n < 3000; n++)
            step_in(($urandom % 200) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
                    ($urandom % 6) == 0, 2'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
